gcd_engine: RTL

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_sub_cmp.sv | 23 ++
 rtl/gcd_engine.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared FSM state type and default width for the GCD engine
package gcd_pkg;

  localparam int GCD_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_sub_cmp.sv
// rtl/gcd_sub_cmp.sv - unsigned magnitude comparator with larger-minus-smaller subtractor
module gcd_sub_cmp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] diff
);

  always_comb begin
    gt   = (a > b);
    lt   = (a < b);
    eq   = (a == b);
    // Always subtract the smaller from the larger so the result never wraps.
    diff = gt ? (a - b) : (b - a);
  end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive GCD engine with valid/ready handshakes; GCD_ITER_CNT_EN adds iter_cnt
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_flag,
  output logic             busy
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  gcd_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             zero_q, zero_d;
  logic             gt, lt, eq;
  logic [WIDTH-1:0] diff;

  gcd_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .a    (a_q),
    .b    (b_q),
    .gt   (gt),
    .lt   (lt),
    .eq   (eq),
    .diff (diff)
  );

`ifdef GCD_ITER_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    zero_d  = zero_q;
`ifdef GCD_ITER_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a_in;
          b_d = b_in;
`ifdef GCD_ITER_CNT_EN
          cnt_d = '0;
`endif
          if ((a_in == '0) || (b_in == '0)) begin
            // With one operand zero the OR is the other operand; both zero gives zero.
            gcd_d   = a_in | b_in;
            zero_d  = (a_in == '0) && (b_in == '0);
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (gt) begin
          a_d = diff;
        end else if (lt) begin
          b_d = diff;
        end
`ifdef GCD_ITER_CNT_EN
        if (!eq && (cnt_q != '1)) begin
          cnt_d = cnt_q + WIDTH'(1);
        end
`endif
        if (eq) begin
          gcd_d   = a_q;
          zero_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      zero_q  <= zero_d;
    end
  end

`ifdef GCD_ITER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iter_cnt = cnt_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign gcd_out   = gcd_q;
  assign zero_flag = zero_q;

endmodule
